// File: rtl/cu_fsm_hs.sv
// Multicycle control unit for the Otter RV32I core with handshaked instruction
// and data memory ports. It adds a bus timeout, prioritised interrupts and a trap path.
module cu_fsm_hs #(
  parameter int NUM_IRQ = 4,
  parameter int TIMEOUT = 16,
  parameter int IDW     = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opcode,
  input  logic [2:0]         func3,
  input  logic [NUM_IRQ-1:0] irq_pend,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               irq_en,
  output logic               imem_req,
  input  logic               imem_ack,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ack,
  output logic               pc_w_en,
  output logic               rfile_w_en,
  output logic               csr_we,
  output logic               cu_rst,
  output logic               int_taken,
  output logic [IDW-1:0]     irq_id,
  output logic               trap,
  output logic               trap_cause
);

  localparam logic [6:0] OPCODE_R_TYPE         = 7'b0110011;
  localparam logic [6:0] OPCODE_I_TYPE_NO_LOAD = 7'b0010011;
  localparam logic [6:0] OPCODE_I_TYPE_LOAD    = 7'b0000011;
  localparam logic [6:0] OPCODE_I_TYPE_JALR    = 7'b1100111;
  localparam logic [6:0] OPCODE_S_TYPE         = 7'b0100011;
  localparam logic [6:0] OPCODE_B_TYPE         = 7'b1100011;
  localparam logic [6:0] OPCODE_LUI            = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC          = 7'b0010111;
  localparam logic [6:0] OPCODE_J_TYPE_JAL     = 7'b1101111;
  localparam logic [6:0] OPCODE_INTRPT         = 7'b1110011;

  localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    FETCH  = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WR_BK  = 3'd4,
    INTRPT = 3'd5,
    TRAP   = 3'd6
  } state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [IDW-1:0]       irq_id_r, irq_win;
  logic                 cause_r, cause_nxt;
  logic [NUM_IRQ-1:0]   irq_vec;
  logic                 irq_hit;
  logic                 retire;
  logic                 is_store;

  // Expiry fires on the last allowed wait cycle; an ack in that cycle wins.
  function automatic logic expired(input logic [CW-1:0] c, input logic ack);
    return (TIMEOUT != 0) && (c == CNT_LAST) && !ack;
  endfunction

  always_comb begin
    irq_vec = irq_pend & irq_mask;
    irq_hit = irq_en & (|irq_vec);
    irq_win = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_vec[i]) irq_win = IDW'(i);
    end
  end

  assign is_store = (opcode == OPCODE_S_TYPE);

  always_comb begin
    state_nxt  = state;
    cause_nxt  = cause_r;
    retire     = 1'b0;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    pc_w_en    = 1'b0;
    rfile_w_en = 1'b0;
    csr_we     = 1'b0;
    cu_rst     = 1'b0;
    int_taken  = 1'b0;
    trap       = 1'b0;
    trap_cause = 1'b0;
    case (state)
      INIT: begin
        cu_rst    = 1'b1;
        state_nxt = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_nxt = EXEC;
        end else if (expired(cnt, imem_ack)) begin
          state_nxt = TRAP;
          cause_nxt = 1'b0;
        end
      end
      EXEC: begin
        case (opcode)
          OPCODE_R_TYPE, OPCODE_I_TYPE_NO_LOAD, OPCODE_I_TYPE_JALR,
          OPCODE_LUI, OPCODE_AUIPC, OPCODE_J_TYPE_JAL: begin
            rfile_w_en = 1'b1;
            pc_w_en    = 1'b1;
            retire     = 1'b1;
          end
          OPCODE_B_TYPE: begin
            pc_w_en = 1'b1;
            retire  = 1'b1;
          end
          OPCODE_I_TYPE_LOAD, OPCODE_S_TYPE: state_nxt = MEM;
          OPCODE_INTRPT: begin
            if (func3 == 3'b000) begin
              pc_w_en = 1'b1;
              retire  = 1'b1;
            end else if (func3[0]) begin
              csr_we     = 1'b1;
              rfile_w_en = 1'b1;
              pc_w_en    = 1'b1;
              retire     = 1'b1;
            end else begin
              state_nxt = TRAP;
              cause_nxt = 1'b1;
            end
          end
          default: begin
            state_nxt = TRAP;
            cause_nxt = 1'b1;
          end
        endcase
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ack) begin
          if (is_store) begin
            pc_w_en = 1'b1;
            retire  = 1'b1;
          end else begin
            state_nxt = WR_BK;
          end
        end else if (expired(cnt, dmem_ack)) begin
          state_nxt = TRAP;
          cause_nxt = 1'b0;
        end
      end
      WR_BK: begin
        rfile_w_en = 1'b1;
        pc_w_en    = 1'b1;
        retire     = 1'b1;
      end
      INTRPT: begin
        int_taken = 1'b1;
        pc_w_en   = 1'b1;
        state_nxt = FETCH;
      end
      TRAP: begin
        trap       = 1'b1;
        trap_cause = cause_r;
        pc_w_en    = 1'b1;
        state_nxt  = FETCH;
      end
      default: state_nxt = INIT;
    endcase
    if (retire) state_nxt = irq_hit ? INTRPT : FETCH;
  end

  // Counter runs only while a request stays in its state, so entry clears it.
  assign cnt_nxt = (((state == FETCH) || (state == MEM)) && (state_nxt == state)) ?
                   cnt + 1'b1 : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      cnt      <= '0;
      irq_id_r <= '0;
      cause_r  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cause_r <= cause_nxt;
      if (retire && irq_hit) irq_id_r <= irq_win;
    end
  end

  assign irq_id = irq_id_r;

endmodule

// File: tb/tb_cu_fsm_hs.sv
// Scoreboard bench for cu_fsm_hs: a driver issues instructions with random memory
// latencies and pushes expected PC-write events; a monitor pops and compares them.
module tb_cu_fsm_hs;
  localparam int NIRQ = 4;
  localparam int TMO  = 4;
  localparam int IDW  = 2;

  localparam int K_ALU = 0, K_BR = 1, K_LD = 2, K_ST = 3, K_CSR = 4, K_MRET = 5, K_ILL = 6;

  logic            clk, rst;
  logic [6:0]      opcode;
  logic [2:0]      func3;
  logic [NIRQ-1:0] irq_pend, irq_mask;
  logic            irq_en;
  logic            imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  logic            pc_w_en, rfile_w_en, csr_we, cu_rst, int_taken, trap, trap_cause;
  logic [IDW-1:0]  irq_id;

  cu_fsm_hs #(.NUM_IRQ(NIRQ), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3),
    .irq_pend(irq_pend), .irq_mask(irq_mask), .irq_en(irq_en),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .pc_w_en(pc_w_en), .rfile_w_en(rfile_w_en), .csr_we(csr_we), .cu_rst(cu_rst),
    .int_taken(int_taken), .irq_id(irq_id), .trap(trap), .trap_cause(trap_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit rf;
    bit csr;
    bit it;
    bit tr;
    bit tc;
    int id;
    int gap;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: expected PC-write events of one instruction, from its latencies.
  task automatic expect_instr(input int kind, input int d_i, input int d_d, input bit en,
                              input logic [NIRQ-1:0] pend, input logic [NIRQ-1:0] mask);
    ev_t e;
    int  f;
    bit  ret;
    logic [NIRQ-1:0] v;
    e   = '{rf: 0, csr: 0, it: 0, tr: 0, tc: 0, id: 0, gap: 0};
    ret = 0;
    if (d_i >= TMO) begin
      e.tr = 1; e.tc = 0; e.gap = TMO + 1;
      exp_q.push_back(e);
      return;
    end
    f = d_i + 1;
    case (kind)
      K_ALU: begin e.rf = 1; e.gap = f + 1; ret = 1; end
      K_BR, K_MRET: begin e.gap = f + 1; ret = 1; end
      K_CSR: begin e.rf = 1; e.csr = 1; e.gap = f + 1; ret = 1; end
      K_ILL: begin e.tr = 1; e.tc = 1; e.gap = f + 2; end
      default: begin
        if (d_d >= TMO) begin
          e.tr = 1; e.tc = 0; e.gap = f + 1 + TMO + 1;
        end else if (kind == K_ST) begin
          e.gap = f + 1 + d_d + 1; ret = 1;
        end else begin
          e.rf = 1; e.gap = f + 1 + d_d + 2; ret = 1;
        end
      end
    endcase
    exp_q.push_back(e);
    v = pend & mask;
    if (ret && en && (v != 0)) begin
      e = '{rf: 0, csr: 0, it: 1, tr: 0, tc: 0, id: 0, gap: 1};
      for (int b = 0; b < NIRQ; b++) begin
        if (v[b]) begin e.id = b; break; end
      end
      exp_q.push_back(e);
    end
  endtask

  // Driver: waits for a fetch, presents the instruction and answers the handshakes.
  task automatic do_instr(input int kind, input logic [6:0] op, input logic [2:0] f3,
                          input int d_i, input int d_d, input bit en,
                          input logic [NIRQ-1:0] pend, input logic [NIRQ-1:0] mask,
                          input bit rst_mid);
    int w;
    w = 0;
    while (!imem_req) begin
      if (w++ > 20) begin
        check("fetch_wait_timeout", 0, 1);
        return;
      end
      @(posedge clk); #1;
    end
    opcode = op; func3 = f3; irq_en = en; irq_pend = pend; irq_mask = mask;
    if (!rst_mid) expect_instr(kind, d_i, d_d, en, pend, mask);
    for (int k = 0; ; k++) begin
      imem_ack = (k == d_i);
      dmem_ack = 1'($urandom_range(0, 1));
      if (k == d_i || k == TMO - 1) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    if (d_i < TMO && (kind == K_LD || kind == K_ST)) begin
      @(posedge clk); #1;
      check("mem_req", dmem_req, 1);
      check("mem_we", dmem_we, (kind == K_ST));
      if (rst_mid) begin
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_cu_rst", cu_rst, 1);
        check("midrst_dmem_req", dmem_req, 0);
        check("midrst_imem_req", imem_req, 0);
        rst = 1'b0;
        return;
      end
      for (int k = 0; ; k++) begin
        dmem_ack = (k == d_d);
        if (k == d_d || k == TMO - 1) break;
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
      dmem_ack = 1'b0;
    end
  endtask

  // Monitor: every PC write is matched against the next expected event.
  int  cyc = 0;
  int  last_ev = 0;
  ev_t m;
  always @(negedge clk) begin
    cyc++;
    if (cu_rst) last_ev = cyc;
    check("strobe_without_pc", (rfile_w_en | csr_we | int_taken | trap) & ~pc_w_en, 0);
    if (!dmem_req) check("we_without_req", dmem_we, 0);
    if (pc_w_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pc_w_en", 1, 0);
      end else begin
        m = exp_q.pop_front();
        check("rfile_w_en", rfile_w_en, m.rf);
        check("csr_we", csr_we, m.csr);
        check("int_taken", int_taken, m.it);
        check("trap", trap, m.tr);
        check("trap_cause", trap_cause, m.tc);
        if (m.it) check("irq_id", irq_id, m.id);
        check("latency", cyc - last_ev, m.gap);
      end
      last_ev = cyc;
    end
  end

  logic [6:0] alu_ops[6] = '{7'b0110011, 7'b0010011, 7'b1100111,
                             7'b0110111, 7'b0010111, 7'b1101111};
  logic [6:0] ill_ops[3] = '{7'b0000000, 7'b0001111, 7'b1111111};

  initial begin
    int kind, di, dd;
    logic [6:0] op;
    logic [2:0] f3;
    rst = 1'b1; opcode = '0; func3 = '0; irq_pend = '0; irq_mask = '0; irq_en = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cu_rst", cu_rst, 1);
    check("rst_imem_req", imem_req, 0);
    check("rst_pc_w_en", pc_w_en, 0);
    check("rst_irq_id", irq_id, 0);
    check("rst_trap", trap, 0);
    rst = 1'b0;

    do_instr(K_ALU, 7'b0110011, 3'b000, 0, 0, 0, 4'b0000, 4'b0000, 0);
    do_instr(K_ALU, 7'b0110011, 3'b000, 0, 0, 0, 4'b0000, 4'b0000, 0);
    do_instr(K_ALU, 7'b0010011, 3'b000, 0, 0, 1, 4'b1010, 4'b1111, 0);
    do_instr(K_ALU, 7'b0010011, 3'b000, 0, 0, 1, 4'b1010, 4'b1101, 0);
    do_instr(K_ALU, 7'b0010011, 3'b000, 0, 0, 0, 4'b1010, 4'b1111, 0);
    do_instr(K_LD,  7'b0000011, 3'b010, 0, 3, 0, 4'b0000, 4'b0000, 0);
    do_instr(K_ALU, 7'b0110011, 3'b000, 5, 0, 0, 4'b0000, 4'b0000, 0);
    do_instr(K_ALU, 7'b0110011, 3'b000, 3, 0, 0, 4'b0000, 4'b0000, 0);
    do_instr(K_ILL, 7'b0000000, 3'b000, 0, 0, 1, 4'b0001, 4'b0001, 0);
    do_instr(K_CSR, 7'b1110011, 3'b001, 0, 0, 0, 4'b0000, 4'b0000, 0);
    do_instr(K_MRET, 7'b1110011, 3'b000, 0, 0, 0, 4'b0000, 4'b0000, 0);
    do_instr(K_ST,  7'b0100011, 3'b010, 0, 0, 0, 4'b0000, 4'b0000, 0);
    do_instr(K_ST,  7'b0100011, 3'b010, 1, 7, 1, 4'b1111, 4'b1111, 0);
    do_instr(K_LD,  7'b0000011, 3'b010, 0, 9, 0, 4'b0000, 4'b0000, 1);

    for (int n = 0; n < 250; n++) begin
      kind = $urandom_range(0, 6);
      di   = ($urandom_range(0, 7) == 0) ? TMO + 1 : $urandom_range(0, TMO - 1);
      dd   = ($urandom_range(0, 7) == 0) ? TMO + 2 : $urandom_range(0, TMO - 1);
      f3   = 3'($urandom_range(0, 7));
      case (kind)
        K_ALU:  op = alu_ops[$urandom_range(0, 5)];
        K_BR:   op = 7'b1100011;
        K_LD:   op = 7'b0000011;
        K_ST:   op = 7'b0100011;
        K_CSR:  begin op = 7'b1110011; f3 = {2'($urandom_range(0, 3)), 1'b1}; end
        K_MRET: begin op = 7'b1110011; f3 = 3'b000; end
        default: begin
          if ($urandom_range(0, 1) == 1) begin
            op = 7'b1110011; f3 = {2'($urandom_range(1, 3)), 1'b0};
          end else begin
            op = ill_ops[$urandom_range(0, 2)];
          end
        end
      endcase
      do_instr(kind, op, f3, di, dd, 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cu_fsm_hs.md
# cu_fsm_hs

Multicycle control unit for the Otter RV32I core with handshaked instruction and data memory ports. It replaces fixed single-cycle memory timing with req/ack handshakes and a configurable bus timeout. It also adds a prioritised multi-source interrupt selector and a trap path for bus timeouts and illegal opcodes. It sits between the instruction register/decoder and the PC, register file, CSR file and memory interface.

## Interface
- NUM_IRQ, default 4: number of interrupt sources, allowed range 1..32.
- TIMEOUT, default 16: maximum number of wait cycles per memory request; 0 disables the timeout.
- IDW, default $clog2(NUM_IRQ) (minimum 1): width of irq_id.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- opcode  in  7  instruction[6:0]; compared against the OPCODE_* constants in OPCODES.vh.
- func3  in  3  instruction[14:12].
- irq_pend  in  NUM_IRQ  level-sensitive pending interrupt lines.
- irq_mask  in  NUM_IRQ  per-source enable.
- irq_en  in  1  global interrupt enable (CSR MIE).
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  instruction fetch complete.
- dmem_req  out  1  data access request.
- dmem_we  out  1  data write qualifier, valid only while dmem_req=1.
- dmem_ack  in  1  data access complete.
- pc_w_en  out  1  PC write enable.
- rfile_w_en  out  1  register file write enable.
- csr_we  out  1  CSR write enable.
- cu_rst  out  1  datapath reset.
- int_taken  out  1  interrupt entry strobe.
- irq_id  out  IDW  index of the interrupt being taken.
- trap  out  1  trap entry strobe.
- trap_cause  out  1  trap reason: 0 = bus timeout, 1 = illegal opcode.

## Operation
- States: INIT, FETCH, EXEC, MEM, WR_BK, INTRPT, TRAP.
- Unless a state says otherwise, every output is 0.
- irq_hit = irq_en & |(irq_pend & irq_mask).
- Priority: the lowest set index of irq_pend & irq_mask wins.
- "Retire" means the instruction completes: go to INTRPT if irq_hit, otherwise go to FETCH.
- On the retire cycle that enters INTRPT, the winning index is registered into irq_id. irq_id holds that value until the next interrupt is taken; its reset value is 0.

State behaviour:
- INIT: cu_rst=1. Next state FETCH.
- FETCH:
  - imem_req=1 until imem_ack.
  - On imem_ack, go to EXEC.
  - Otherwise, on timeout expiry, go to TRAP with cause 0.
- EXEC, decoded by opcode:
  - R_TYPE, I_TYPE_NO_LOAD, I_TYPE_JALR, LUI, AUIPC, J_TYPE_JAL: rfile_w_en=1, pc_w_en=1, retire.
  - B_TYPE: pc_w_en=1, retire.
  - I_TYPE_LOAD and S_TYPE: no outputs, go to MEM.
  - INTRPT (SYSTEM), func3==000 (mret): pc_w_en=1, retire.
  - INTRPT (SYSTEM), func3[0]==1 (csrrw): csr_we=1, rfile_w_en=1, pc_w_en=1, retire.
  - Any other opcode or SYSTEM func3: go to TRAP with cause 1, with no write enables.
- MEM:
  - dmem_req=1; dmem_we=1 for stores.
  - Store with dmem_ack: pc_w_en=1 in the same cycle, retire.
  - Load with dmem_ack: go to WR_BK.
  - Without ack, timeout expiry goes to TRAP with cause 0.
- WR_BK: rfile_w_en=1, pc_w_en=1, retire.
- INTRPT: int_taken=1, pc_w_en=1. Next state FETCH.
- TRAP: trap=1, pc_w_en=1; trap_cause comes from a register latched on entry. Next state FETCH. A trap never chains directly into INTRPT.

Timeout counter:
- Width $clog2(TIMEOUT+1). Cleared on entry to FETCH and MEM.
- Increments on each request cycle without an ack.
- Expiry occurs when the count equals TIMEOUT-1 and no ack is present, so a request is held for exactly TIMEOUT cycles.
- If ack and expiry fall in the same cycle, the ack wins.
- With TIMEOUT=0, requests wait forever.
- Any undefined state encoding goes to INIT.

## Timing
- All state, irq_id, trap_cause and counter updates are registered on clk. Outputs are combinational from state, opcode/func3 and ack.
- Reset:
  - While rst=1, the state is forced to INIT at each edge, so cu_rst=1 and all other outputs are 0.
  - A reset mid-request drops imem_req/dmem_req in the cycle after the edge.
- Minimum latency with zero-wait memory (ack in the request cycle):
  - ALU, branch and jump: 2 cycles.
  - Store: 3 cycles.
  - Load: 4 cycles.
  - Interrupt entry adds 1 cycle; trap takes 1 cycle.
- Handshake:
  - A request asserts on state entry and holds until the ack cycle, then deasserts next cycle.
  - Ack outside a request is ignored.
- Interrupts are sampled only on retire cycles. An irq_pend pulse that misses every retire cycle is lost.

## Test plan
- After reset release: 1 INIT cycle with cu_rst=1, then FETCH. With imem_ack tied to 1 and opcode R_TYPE, pc_w_en and rfile_w_en pulse every 2nd cycle.
- Load with dmem_ack delayed 3 cycles: dmem_req high for 4 cycles with dmem_we=0, then WR_BK with rfile_w_en=1 and pc_w_en=1; total latency 7 cycles.
- TIMEOUT=4, imem_ack held at 0: imem_req high exactly 4 cycles, then trap=1, trap_cause=0, pc_w_en=1, then FETCH. Repeat with ack arriving in cycle 4: no trap.
- irq_pend=4'b1010, irq_mask=4'b1111, irq_en=1 during an ADDI retire: INTRPT next with int_taken=1 and irq_id=1. Repeat with irq_mask=4'b1101: irq_id=3. Repeat with irq_en=0: no INTRPT.
- Opcode 7'b0000000: TRAP with trap_cause=1 and no rfile_w_en. csrrw (func3=001): csr_we=rfile_w_en=pc_w_en=1. mret (func3=000): only pc_w_en=1.
- Assert rst during MEM wait: next cycle INIT with dmem_req=0, then normal fetch restart.
